// File: rtl/axi_master_pkg.sv
`default_nettype none
// =============================================================================
// axi_master_pkg : shared types and constants for the single-beat AXI master.
// Revision: 1.0
// =============================================================================
package axi_master_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 4;

    localparam logic [1:0]       BURST_INCR = 2'b01;
    localparam logic [2:0]       SIZE_WORD  = 3'b010;
    localparam logic [1:0]       RESP_OKAY  = 2'b00;
    localparam logic [LEN_W-1:0] LEN_SINGLE = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/master_core_timer.sv
`default_nettype none
// =============================================================================
// master_core_timer : 8-bit response watchdog, held clear while i_run is low.
// Revision: 1.0
// =============================================================================
module master_core_timer #(
    parameter logic [7:0] TO_CYCLES = 8'd255
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic i_run,
    output logic o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_count <= '0;
        end else if (!i_run) begin
            r_count <= '0;
        end else if (!o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_run && (r_count == TO_CYCLES);

endmodule
`default_nettype wire

// File: rtl/master_core.sv
`default_nettype none
// =============================================================================
// master_core : single-beat AXI master behind a stalling CPU request port.
// Optional feature: define MASTER_CORE_TIMEOUT_EN for an R/B response timeout.
// Revision: 1.0
// =============================================================================
module master_core
    import axi_master_pkg::*;
#(
    parameter logic [ID_W-1:0] MASTER_ID = 4'd0,
    parameter logic [7:0]      TO_CYCLES = 8'd255
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    input  logic [STRB_W-1:0]  cpu_wstrb,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_stall,
    output logic               cpu_err,
    output logic [ID_W-1:0]    AWID,
    output logic [ADDR_W-1:0]  AWADDR,
    output logic [LEN_W-1:0]   AWLEN,
    output logic [2:0]         AWSIZE,
    output logic [1:0]         AWBURST,
    output logic               AWVALID,
    input  logic               AWREADY,
    output logic [DATA_W-1:0]  WDATA,
    output logic [STRB_W-1:0]  WSTRB,
    output logic               WLAST,
    output logic               WVALID,
    input  logic               WREADY,
    input  logic [ID_W-1:0]    BID,
    input  logic [1:0]         BRESP,
    input  logic               BVALID,
    output logic               BREADY,
    output logic [ID_W-1:0]    ARID,
    output logic [ADDR_W-1:0]  ARADDR,
    output logic [LEN_W-1:0]   ARLEN,
    output logic [2:0]         ARSIZE,
    output logic [1:0]         ARBURST,
    output logic               ARVALID,
    input  logic               ARREADY,
    input  logic [ID_W-1:0]    RID,
    input  logic [DATA_W-1:0]  RDATA,
    input  logic [1:0]         RRESP,
    input  logic               RLAST,
    input  logic               RVALID,
    output logic               RREADY
);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;

    logic                w_r_fire;
    logic                w_b_fire;
    logic                w_r_bad;
    logic                w_b_bad;
    logic                w_timeout;
    logic                w_stall;

    assign w_r_fire = (r_state == ST_R) && RVALID && RLAST;
    assign w_b_fire = (r_state == ST_B) && BVALID;
    assign w_r_bad  = (RRESP != RESP_OKAY) || (RID != MASTER_ID);
    assign w_b_bad  = (BRESP != RESP_OKAY) || (BID != MASTER_ID);

`ifdef MASTER_CORE_TIMEOUT_EN
    logic w_timer_run;

    assign w_timer_run = (r_state == ST_R) || (r_state == ST_B);

    master_core_timer #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timer (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .i_run     (w_timer_run),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_to_cycles;

    assign w_unused_to_cycles = ^TO_CYCLES;
    assign w_timeout          = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_wstrb <= cpu_wstrb;
                        if (cpu_wr) begin
                            r_state   <= ST_AW;
                            r_awvalid <= 1'b1;
                        end else begin
                            r_state   <= ST_AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    // A real response wins over a timeout landing in the same cycle.
                    if (RVALID && RLAST) begin
                        r_rready <= 1'b0;
                        r_rdata  <= RDATA;
                        r_err    <= w_r_bad;
                        r_state  <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_rready <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (WREADY) begin
                        r_wvalid <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (BVALID) begin
                        r_bready <= 1'b0;
                        r_err    <= w_b_bad;
                        r_state  <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_bready <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                end
            endcase
        end
    end

    // Stall drops in the completing cycle so the CPU can move on at the next edge.
    always_comb begin
        w_stall = 1'b0;
        if (!ARESET) begin
            case (r_state)
                ST_IDLE: w_stall = cpu_req;
                ST_R:    w_stall = !w_r_fire && !w_timeout;
                ST_B:    w_stall = !w_b_fire && !w_timeout;
                default: w_stall = 1'b1;
            endcase
        end
    end

    assign cpu_stall = w_stall;
    assign cpu_rdata = r_rdata;
    assign cpu_err   = r_err;

    assign AWID    = MASTER_ID;
    assign AWADDR  = r_addr;
    assign AWLEN   = LEN_SINGLE;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign AWVALID = r_awvalid;

    assign WDATA   = r_wdata;
    assign WSTRB   = r_wstrb;
    assign WLAST   = 1'b1;
    assign WVALID  = r_wvalid;

    assign BREADY  = r_bready;

    assign ARID    = MASTER_ID;
    assign ARADDR  = r_addr;
    assign ARLEN   = LEN_SINGLE;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign ARVALID = r_arvalid;

    assign RREADY  = r_rready;

endmodule
`default_nettype wire
